// File: rtl/rf_wr_sched.sv
// Write-port scheduler for the 8x16 register file.
// Shares the single register-file write port between NREQ writeback requesters
// using round-robin valid/ready arbitration. It also runs an on-demand
// 8-cycle register-clear sequence and keeps a pending-write busy mask for decode.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_addr/data/hi    per-requester write payload, packed by requester index
//   clr_start/clr_busy  clear-sequence trigger and in-progress flag
//   resv_set/resv_addr  decode reservation of a destination register
//   busy_mask           bit k set while a write to register k is pending
//   rf_*                registered write port toward the register file
//   rf_grant_id         source of the current write (NREQ = clear sequence)
module rf_wr_sched #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 3,
    parameter int unsigned GW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_hi,
    input  logic                 clr_start,
    output logic                 clr_busy,
    input  logic                 resv_set,
    input  logic [AW-1:0]        resv_addr,
    output logic [2**AW-1:0]     busy_mask,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_data,
    output logic                 rf_only_high,
    output logic                 rf_write_en,
    output logic [GW-1:0]        rf_grant_id
);

    localparam int unsigned NREG = 2**AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW-1:0]   rf_addr_q, rf_addr_d;
    logic [DW-1:0]   rf_data_q, rf_data_d;
    logic            rf_hi_q, rf_hi_d;
    logic            rf_we_q, rf_we_d;
    logic [GW-1:0]   rf_gid_q, rf_gid_d;

    logic            arb_found;
    logic [GW-1:0]   arb_win;
    logic [GW-1:0]   arb_cand;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            win_hi;
    logic            grant_en;

    // Round-robin search starting just after the last winner.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = rr_ptr_q;
        for (int unsigned off = 0; off < NREQ; off++) begin
            arb_cand = (arb_cand == GW'(NREQ - 1)) ? '0 : arb_cand + GW'(1);
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!arb_found && req_valid[i] && (arb_cand == GW'(i))) begin
                    arb_found = 1'b1;
                    arb_win   = GW'(i);
                end
            end
        end
    end

    // Payload of the current winner.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_hi   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_win == GW'(i)) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
                win_hi   = req_hi[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clr_start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_start) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == AW'(NREG - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; a clear request in IDLE blocks every grant that cycle.
    always_comb begin
        grant_en  = 1'b0;
        clr_busy  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE:    grant_en = rst && !clr_start && arb_found;
            CLEAR:   clr_busy = 1'b1;
            default: grant_en = 1'b0;
        endcase
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_en && (arb_win == GW'(i));
        end
    end

    // Write-port, pointer, clear-counter and scoreboard next values.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        clr_cnt_d = '0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        rf_hi_d   = rf_hi_q;
        rf_gid_d  = rf_gid_q;
        rf_we_d   = 1'b0;
        busy_d    = busy_q;

        if (grant_en) begin
            rr_ptr_d  = arb_win;
            rf_addr_d = win_addr;
            rf_data_d = win_data;
            rf_hi_d   = win_hi;
            rf_gid_d  = arb_win;
            rf_we_d   = 1'b1;
        end else if (state_q == CLEAR) begin
            rf_addr_d = clr_cnt_q;
            rf_data_d = '0;
            rf_hi_d   = 1'b0;
            rf_gid_d  = GW'(NREQ);
            rf_we_d   = 1'b1;
            // Wraps to 0 naturally after the last register.
            clr_cnt_d = clr_cnt_q + AW'(1);
        end

        // Commit clears first so a same-edge reservation wins.
        if (rf_we_q) begin
            busy_d[rf_addr_q] = 1'b0;
        end
        if (resv_set) begin
            busy_d[resv_addr] = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q  <= GW'(NREQ - 1);
            clr_cnt_q <= '0;
            busy_q    <= '0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            rf_hi_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_gid_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            rf_hi_q   <= rf_hi_d;
            rf_we_q   <= rf_we_d;
            rf_gid_q  <= rf_gid_d;
        end
    end

    assign busy_mask    = busy_q;
    assign rf_addr      = rf_addr_q;
    assign rf_data      = rf_data_q;
    assign rf_only_high = rf_hi_q;
    assign rf_write_en  = rf_we_q;
    assign rf_grant_id  = rf_gid_q;

endmodule

// File: tb/tb_rf_wr_sched.sv
// Self-checking bench for rf_wr_sched: scenario tasks with a scoreboard queue of
// expected register-file writes, each tagged with the cycle it must appear in.
module tb_rf_wr_sched;

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 3;
    localparam int unsigned GW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_hi;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 resv_set;
    logic [AW-1:0]        resv_addr;
    logic [7:0]           busy_mask;
    logic [AW-1:0]        rf_addr;
    logic [DW-1:0]        rf_data;
    logic                 rf_only_high;
    logic                 rf_write_en;
    logic [GW-1:0]        rf_grant_id;

    always #5 clk = ~clk;

    rf_wr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW), .GW(GW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_hi(req_hi),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .resv_set(resv_set), .resv_addr(resv_addr), .busy_mask(busy_mask),
        .rf_addr(rf_addr), .rf_data(rf_data), .rf_only_high(rf_only_high),
        .rf_write_en(rf_write_en), .rf_grant_id(rf_grant_id)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          hi;
        logic [GW-1:0] gid;
    } wr_t;

    typedef struct {
        int  due;
        wr_t w;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_wr(input int due, input int addr, input int data, input int hi, input int gid);
        sb_t s;
        s.due    = due;
        s.w.addr = AW'(addr);
        s.w.data = DW'(data);
        s.w.hi   = 1'(hi);
        s.w.gid  = GW'(gid);
        sb_q.push_back(s);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b required 000", req_ready); end
            n_checks++;
            if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", rf_write_en); end
            n_checks++;
            if (busy_mask !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h required 00", busy_mask); end
            n_checks++;
            if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clr_busy: got %b required 0", clr_busy); end
        end
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        sb_q.delete();
    endtask

    task automatic test_single();
        sb_t s;
        req_valid            = 3'b010;
        req_addr[1*AW +: AW] = 3'd5;
        req_data[1*DW +: DW] = 16'hBEEF;
        req_hi               = '0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b required 010", req_ready); end
        push_wr(cyc + 1, 5, 16'hBEEF, 0, 1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0 || sb_q[0].due != cyc) begin
            n_fail++; $display("FAIL single_write: no expected write due at cycle %0d", cyc);
        end else begin
            s = sb_q.pop_front();
            if ({rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id} !== {1'b1, s.w}) begin
                n_fail++;
                $display("FAIL single_write: got %h required %h", {rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id}, {1'b1, s.w});
            end
        end
        n_checks++;
        if (req_ready !== 3'b000) begin n_fail++; $display("FAIL single_ready_off: got %b required 000", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL single_we_off: got %b required 0", rf_write_en); end
        n_checks++;
        if (rf_addr !== 3'd5 || rf_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL single_hold: got addr %0d data %h required addr 5 data beef", rf_addr, rf_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        sb_t             s;
        logic [NREQ-1:0] exp_r;
        int              w;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 1);
            req_data[i*DW +: DW] = DW'(16'hA000 + i);
        end
        req_hi    = 3'b100;
        req_valid = '1;
        for (int k = 0; k <= 6; k++) begin
            if (k == 6) req_valid = '0;
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                s = sb_q.pop_front();
                n_checks++;
                if ({rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id} !== {1'b1, s.w}) begin
                    n_fail++;
                    $display("FAIL rr_write k=%0d: got %h required %h", k, {rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id}, {1'b1, s.w});
                end
            end else begin
                n_checks++;
                if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle k=%0d: got we %b required 0", k, rf_write_en); end
            end
            if (k < 6) begin
                w        = k % 3;
                exp_r    = '0;
                exp_r[w] = 1'b1;
                n_checks++;
                if (req_ready !== exp_r) begin n_fail++; $display("FAIL rr_ready k=%0d: got %b required %b", k, req_ready, exp_r); end
                push_wr(cyc + 1, w + 1, 16'hA000 + w, (w == 2) ? 1 : 0, w);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_clear_vs_req();
        sb_t             s;
        logic [NREQ-1:0] exp_r;
        logic            exp_cb;
        req_valid            = 3'b001;
        req_addr[0 +: AW]    = 3'd6;
        req_data[0 +: DW]    = 16'h1234;
        req_hi               = '0;
        clr_start            = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 1)  clr_start = 1'b0;
            if (k == 3)  clr_start = 1'b1;
            if (k == 4)  clr_start = 1'b0;
            if (k == 10) req_valid = '0;
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                s = sb_q.pop_front();
                n_checks++;
                if ({rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id} !== {1'b1, s.w}) begin
                    n_fail++;
                    $display("FAIL clr_write k=%0d: got %h required %h", k, {rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id}, {1'b1, s.w});
                end
            end else begin
                n_checks++;
                if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL clr_idle k=%0d: got we %b required 0", k, rf_write_en); end
            end
            exp_r  = (k == 9) ? 3'b001 : 3'b000;
            exp_cb = (k >= 1 && k <= 8);
            n_checks++;
            if (req_ready !== exp_r) begin n_fail++; $display("FAIL clr_ready k=%0d: got %b required %b", k, req_ready, exp_r); end
            n_checks++;
            if (clr_busy !== exp_cb) begin n_fail++; $display("FAIL clr_busy k=%0d: got %b required %b", k, clr_busy, exp_cb); end
            if (k == 0) begin
                for (int c = 0; c < 8; c++) push_wr(cyc + 2 + c, c, 0, 0, NREQ);
            end
            if (k == 9) push_wr(cyc + 1, 6, 16'h1234, 0, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_scoreboard();
        sb_t  s;
        int   resv_tab[8]  = '{1, 0, 0, 1, 0, 1, 1, 0};
        int   raddr_tab[8] = '{2, 2, 2, 2, 2, 2, 7, 0};
        int   val_tab[8]   = '{0, 4, 0, 0, 4, 0, 0, 0};
        int   busy_tab[8]  = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 8'h04, 8'h84};
        req_addr[2*AW +: AW] = 3'd2;
        req_data[2*DW +: DW] = 16'h5555;
        req_hi               = '0;
        for (int k = 0; k < 8; k++) begin
            resv_set  = 1'(resv_tab[k]);
            resv_addr = AW'(raddr_tab[k]);
            req_valid = NREQ'(val_tab[k]);
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                s = sb_q.pop_front();
                n_checks++;
                if ({rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id} !== {1'b1, s.w}) begin
                    n_fail++;
                    $display("FAIL sb_write k=%0d: got %h required %h", k, {rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id}, {1'b1, s.w});
                end
            end else begin
                n_checks++;
                if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL sb_idle k=%0d: got we %b required 0", k, rf_write_en); end
            end
            n_checks++;
            if (busy_mask !== 8'(busy_tab[k])) begin
                n_fail++; $display("FAIL sb_busy k=%0d: got %h required %h", k, busy_mask, 8'(busy_tab[k]));
            end
            n_checks++;
            if (req_ready !== NREQ'(val_tab[k])) begin
                n_fail++; $display("FAIL sb_ready k=%0d: got %b required %b", k, req_ready, NREQ'(val_tab[k]));
            end
            if (val_tab[k] != 0) push_wr(cyc + 1, 2, 16'h5555, 0, 2);
            @(posedge clk); #1;
        end
        resv_set  = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_reset_mid_clear();
        sb_t s;
        clr_start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k == 1) clr_start = 1'b0;
            if (k == 5) rst = 1'b0;
            if (k == 6) rst = 1'b1;
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                n_checks++;
                if (rf_write_en !== 1'b1 || rf_addr !== AW'(k - 2) || rf_grant_id !== GW'(NREQ)) begin
                    n_fail++;
                    $display("FAIL midclr_write k=%0d: got we %b addr %0d id %0d required we 1 addr %0d id %0d", k, rf_write_en, rf_addr, rf_grant_id, k - 2, NREQ);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy: got %b required 0", clr_busy); end
                n_checks++;
                if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL midclr_we: got %b required 0", rf_write_en); end
                n_checks++;
                if (busy_mask !== 8'h00) begin n_fail++; $display("FAIL midclr_mask: got %h required 00", busy_mask); end
            end
            @(posedge clk); #1;
        end
        clr_start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 1) clr_start = 1'b0;
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                s = sb_q.pop_front();
                n_checks++;
                if ({rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id} !== {1'b1, s.w}) begin
                    n_fail++;
                    $display("FAIL restart_write k=%0d: got %h required %h", k, {rf_write_en, rf_addr, rf_data, rf_only_high, rf_grant_id}, {1'b1, s.w});
                end
            end else begin
                n_checks++;
                if (rf_write_en !== 1'b0) begin n_fail++; $display("FAIL restart_idle k=%0d: got we %b required 0", k, rf_write_en); end
            end
            if (k == 0) begin
                for (int c = 0; c < 8; c++) push_wr(cyc + 2 + c, c, 0, 0, NREQ);
            end
            if (k == 1) begin
                n_checks++;
                if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b required 1", clr_busy); end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d writes outstanding required 0", sb_q.size()); end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_hi    = '0;
        clr_start = 1'b0;
        resv_set  = 1'b0;
        resv_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_clear_vs_req();
        test_scoreboard();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/rf_wr_sched.md
Name: rf_wr_sched

Overview:
Write-port scheduler for the 8x16 CPU register file, which has a single write port and two read ports. It shares that write port between NREQ writeback requesters using round-robin valid/ready arbitration. It runs an 8-cycle register-clear sequence on demand, and keeps a pending-write scoreboard (busy mask) that decode uses for stall decisions. It sits between the writeback stages and the register file's addr/data_in/only_high/write_en inputs.

Parameters:
NREQ, 3, number of writeback requesters (2..4)
DW, 16, register data width
AW, 3, register address width (NREG = 2**AW = 8)
GW, 2, grant-id width, equal to $clog2(NREQ+1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
req_addr  in  NREQ*AW  target register, requester i at [i*AW +: AW]
req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
req_hi  in  NREQ  high-byte-only write (mvhi) flag per requester
clr_start  in  1  pulse: start zeroing all 8 registers
clr_busy  out  1  high while the clear sequence runs
resv_set  in  1  decode reserves a destination register
resv_addr  in  AW  register being reserved
busy_mask  out  8  bit k = write to register k pending
rf_addr  out  AW  to register file addr
rf_data  out  DW  to register file data_in
rf_only_high  out  1  to register file only_high
rf_write_en  out  1  to register file write_en
rf_grant_id  out  GW  source of the current write; value NREQ means the clear sequence

Behaviour:
- Reset (rst=0 at an edge), regardless of FSM state: all rf_* outputs = 0, busy_mask = 0, clr_busy = 0, state = IDLE, rr_ptr = NREQ-1, clear counter = 0. req_ready = 0 while rst = 0. A clear in progress is aborted.
- FSM states:
  - IDLE -> CLEAR when clr_start=1.
  - CLEAR -> IDLE after the write for register 7 is issued.
  - clr_start is ignored while in CLEAR.
- Arbitration (IDLE only, combinational):
  - Search order is rr_ptr+1, rr_ptr+2, ... mod NREQ. The first requester with valid=1 wins, and only its req_ready is asserted.
  - req_ready may depend combinationally on req_valid. A requester holds valid and its payload stable until ready is asserted.
  - A handshake (valid & ready) updates rr_ptr to the winner at the next edge.
- Write issue latency is 1 cycle:
  - A handshake in cycle N gives rf_write_en=1 in cycle N+1, with rf_addr, rf_data, rf_only_high and rf_grant_id registered from the winner. The register file commits at the end of N+1.
  - A cycle with no handshake and no clear gives rf_write_en=0 next cycle. The other rf_* outputs hold their values.
  - Back-to-back grants give one write per cycle, sustained.
- Clear priority: in IDLE, if clr_start=1 then all req_ready=0 that cycle, even when requests are valid.
- Clear sequence:
  - In CLEAR, req_ready=0.
  - Each CLEAR cycle with counter c registers a write of data 0, only_high=0, addr c, grant_id NREQ, then increments c.
  - c runs 0..7, giving 8 CLEAR cycles. rf_write_en is high for the 8 cycles after each.
  - clr_busy = (state==CLEAR). clr_start in IDLE gives clr_busy=1 in the next cycle.
  - The counter wraps to 0 on exit.
- Scoreboard:
  - busy_mask[k] sets at the edge after resv_set=1 with resv_addr=k.
  - busy_mask[k] clears at the edge ending a cycle where rf_write_en=1 and rf_addr=k. This applies to high-only and clear writes too.
  - Same edge set and clear on the same k: set wins, so the bit stays 1.
  - resv_set is accepted in every state, including CLEAR.
  - Multiple reservations of the same register are not counted. One commit clears the bit.
- No data transformation: req_data is passed through unchanged. High-byte merging is done by the register file.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, rf_write_en=0, busy_mask=0, clr_busy=0.
2. Single requester: req1 valid with addr 5, data 16'hBEEF, hi=0 in cycle N -> req_ready=3'b010 in N; in N+1 rf_write_en=1, rf_addr=5, rf_data=16'hBEEF, rf_grant_id=1; in N+2 rf_write_en=0.
3. Round-robin: all 3 requesters held valid for 6 cycles after reset -> grant order 0,1,2,0,1,2 with rf_write_en=1 every cycle.
4. Clear versus request: clr_start=1 and req0 valid in the same cycle -> req0 not granted. rf_write_en=1 for 8 consecutive cycles with rf_addr 0..7, rf_data 0, rf_grant_id=3. req0 is granted in the first IDLE cycle after that.
5. Scoreboard: resv_set addr 2, then req2 writes addr 2 -> busy_mask=8'h04 until the edge after the commit cycle, then 8'h00. Repeat with resv_set addr 2 in the commit cycle -> busy_mask stays 8'h04.
6. Reset mid-clear: rst=0 while counter = 4 -> next cycle clr_busy=0, rf_write_en=0, state IDLE. A new clr_start then restarts the clear at addr 0.
